seg_message_sequencer: RTL

Playback controller that stores a short ASCII message and presents it one character at a time to the 7-segment character decoder, holding each for a programmable dwell with an optional blank gap between characters. It sits between the host-side character loader (the tile inputs) and the decoder's 8-bit `char` input. It owns message buffering, the display timing, looping and stop/start sequencing.

---
 rtl/seg_seq_pkg.sv | 19 +
 rtl/seg_dwell_timer.sv | 29 ++
 rtl/seg_message_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seg_seq_pkg.sv
// Shared types and helpers for the 7-segment message sequencer.
package seg_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } seq_state_t;

    localparam logic [7:0] CHAR_BLANK = 8'h00;

    // Width of a down-counter that must hold the larger of the two dwell lengths.
    function automatic int cnt_width(input int tick, input int gap);
        int m;
        m = (tick > gap) ? tick : gap;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/seg_dwell_timer.sv
// Loadable down-counter shared by the SHOW and GAP dwell periods.
// expire marks the final cycle of the loaded period while the timer runs.
module seg_dwell_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expire
);

    logic [CW-1:0] cnt;

    // Reload on state entry, otherwise count down to zero and hold there.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/seg_message_sequencer.sv
// Message buffer plus playback FSM feeding the 7-segment character decoder.
module seg_message_sequencer
    import seg_seq_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int TICK_DIV   = 10_000_000,
    parameter int GAP_CYCLES = 2_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [7:0]                 wr_char,
    input  logic                       clear,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       loop_en,
    output logic [7:0]                 char,
    output logic                       char_valid,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] len
);

    localparam int CW     = cnt_width(TICK_DIV, GAP_CYCLES);
    localparam int IW     = $clog2(DEPTH);
    localparam int LW     = $clog2(DEPTH + 1);
    localparam int GAP_M1 = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [CW-1:0] TICK_LOAD = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_M1);
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);

    seq_state_t    state;
    logic [7:0]    msg_mem [DEPTH];
    logic [IW-1:0] idx;
    logic [IW-1:0] nidx;
    logic [LW-1:0] idx_inc;
    logic          wr_fire;
    logic          start_go;
    logic          more;
    logic          slot_next;
    logic          tmr_load;
    logic          tmr_expire;
    logic [CW-1:0] tmr_val;

    assign wr_ready  = (state == IDLE) && (len < DEPTH_L);
    assign wr_fire   = wr_valid && wr_ready && !clear;
    // Effective length includes a same-cycle write; clear forces it to zero.
    assign start_go  = (state == IDLE) && start && !stop && !clear && ((len != '0) || wr_fire);
    assign idx_inc   = LW'(idx) + LW'(1);
    assign more      = idx_inc < len;
    assign slot_next = more || loop_en;
    assign nidx      = more ? idx + 1'b1 : '0;

    // Decide when the dwell timer reloads: on every entry into SHOW or GAP.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TICK_LOAD;
        if (start_go) begin
            tmr_load = 1'b1;
        end else if ((state != IDLE) && !stop && tmr_expire) begin
            if ((state == SHOW) && (GAP_CYCLES > 0)) begin
                tmr_load = 1'b1;
                tmr_val  = GAP_LOAD;
            end else if (slot_next) begin
                tmr_load = 1'b1;
            end
        end
    end

    seg_dwell_timer #(
        .CW(CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (state != IDLE),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Message storage; only len is reset, contents are don't-care beyond len.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            msg_mem[len[IW-1:0]] <= wr_char;
        end
    end

    // Playback FSM with registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            idx        <= '0;
            char       <= CHAR_BLANK;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        len <= '0;
                    end else if (wr_fire) begin
                        len <= len + 1'b1;
                    end
                    if (start_go) begin
                        state      <= SHOW;
                        idx        <= '0;
                        // An empty buffer can only start via a same-cycle write to slot 0.
                        char       <= (len == '0) ? wr_char : msg_mem[0];
                        char_valid <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                default: begin
                    if (stop) begin
                        state      <= IDLE;
                        char       <= CHAR_BLANK;
                        char_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (tmr_expire && (state == SHOW) && (GAP_CYCLES > 0)) begin
                        state      <= GAP;
                        char       <= CHAR_BLANK;
                        char_valid <= 1'b0;
                    end else if (tmr_expire) begin
                        if (slot_next) begin
                            state      <= SHOW;
                            idx        <= nidx;
                            char       <= msg_mem[nidx];
                            char_valid <= 1'b1;
                        end else begin
                            state      <= IDLE;
                            char       <= CHAR_BLANK;
                            char_valid <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
